color_symbol_reader: RTL and testbench

Controller that sits directly downstream of the TCS3200 color detector. It issues single-cycle `startDetection` pulses and consumes each `detectionComplete`/`color` result. A symbol is accepted only after `CONFIRM` consecutive identical readings, and accepted symbols are packed into a `SYMBOLS`-wide word for the game/ROM logic. The block also guards against a silent or unstable sensor with a per-reading timeout and a retry limit.

---
 rtl/color_symbol_reader_if.sv | 31 +++
 rtl/color_symbol_reader.sv | 139 +++++++++++++
 tb/tb_color_symbol_reader.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/color_symbol_reader_if.sv
// Bundle between the symbol reader and its neighbours: request/clear from the game logic,
// start/result with the TCS3200 detector, and the packed symbol word going back out.
interface color_symbol_reader_if #(
  parameter int SYMBOLS = 4
);
  logic                   readRequest;
  logic                   clearWord;
  logic                   detectionComplete;
  logic [1:0]             color;
  logic                   startDetection;
  logic                   busy;
  logic                   symbolValid;
  logic [1:0]             symbol;
  logic [2*SYMBOLS-1:0]   word;
  logic [3:0]             symbolCount;
  logic                   wordValid;
  logic                   error;
  logic [1:0]             errorCode;

  modport master (
    input  readRequest, clearWord, detectionComplete, color,
    output startDetection, busy, symbolValid, symbol, word, symbolCount,
           wordValid, error, errorCode
  );

  modport slave (
    output readRequest, clearWord, detectionComplete, color,
    input  startDetection, busy, symbolValid, symbol, word, symbolCount,
           wordValid, error, errorCode
  );
endinterface

// File: rtl/color_symbol_reader.sv
// Confirms CONFIRM identical detector readings per symbol and packs symbols into a word.
// All outputs registered one cycle behind the FSM state; no backpressure, requests while busy are dropped.
module color_symbol_reader #(
  parameter int          SYMBOLS    = 4,
  parameter int          CONFIRM    = 3,
  parameter int          MAX_TRIES  = 8,
  parameter int          GAP_CYCLES = 256,
  parameter logic [23:0] TIMEOUT    = 24'd4000000
) (
  input  logic                 clk,
  input  logic                 reset,
  color_symbol_reader_if.master bus
);

  typedef enum logic [2:0] {IDLE, START, WAIT_DONE, GAP, ACCEPT, ERROR} state_t;

  state_t               state, stateNext;
  logic [3:0]           tryCount, matchCount, tryNext, matchNext;
  logic [1:0]           lastColor, errKind;
  logic [23:0]          timer;
  logic [15:0]          gapCnt;

  logic                 startDetection, busy, symbolValid, wordValid, error;
  logic [1:0]           symbol, errorCode;
  logic [2*SYMBOLS-1:0] word;
  logic [3:0]           symbolCount;

  assign bus.startDetection = startDetection;
  assign bus.busy           = busy;
  assign bus.symbolValid    = symbolValid;
  assign bus.symbol         = symbol;
  assign bus.word           = word;
  assign bus.symbolCount    = symbolCount;
  assign bus.wordValid      = wordValid;
  assign bus.error          = error;
  assign bus.errorCode      = errorCode;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    tryNext   = tryCount + 4'd1;
    matchNext = (matchCount == 4'd0 || bus.color == lastColor) ? matchCount + 4'd1 : 4'd1;
    case (state)
      IDLE:      if (bus.readRequest) stateNext = START;
      START:     stateNext = WAIT_DONE;
      WAIT_DONE: begin
        // A result on the timeout cycle still counts as a reading.
        if (bus.detectionComplete) begin
          if (matchNext == 4'(CONFIRM))       stateNext = ACCEPT;
          else if (tryNext == 4'(MAX_TRIES))  stateNext = ERROR;
          else                                stateNext = GAP;
        end else if (timer == TIMEOUT - 24'd1) begin
          stateNext = ERROR;
        end
      end
      GAP:       if (gapCnt == 16'(GAP_CYCLES - 1)) stateNext = START;
      ACCEPT:    stateNext = IDLE;
      ERROR:     stateNext = IDLE;
      default:   stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tryCount       <= 4'd0;
      matchCount     <= 4'd0;
      lastColor      <= 2'd0;
      errKind        <= 2'd0;
      timer          <= 24'd0;
      gapCnt         <= 16'd0;
      startDetection <= 1'b0;
      busy           <= 1'b0;
      symbolValid    <= 1'b0;
      error          <= 1'b0;
      symbol         <= 2'd0;
      errorCode      <= 2'd0;
    end else begin
      startDetection <= (state == START);
      busy           <= (state != IDLE);
      symbolValid    <= (state == ACCEPT);
      error          <= (state == ERROR);
      gapCnt         <= 16'd0;
      case (state)
        IDLE: begin
          tryCount   <= 4'd0;
          matchCount <= 4'd0;
          if (bus.readRequest) errorCode <= 2'd0;
        end
        START:     timer <= 24'd0;
        WAIT_DONE: begin
          timer <= timer + 24'd1;
          if (bus.detectionComplete) begin
            tryCount   <= tryNext;
            matchCount <= matchNext;
            lastColor  <= bus.color;
          end
          if (stateNext == ERROR) errKind <= bus.detectionComplete ? 2'b10 : 2'b01;
        end
        GAP:       gapCnt <= gapCnt + 16'd1;
        ACCEPT:    symbol <= lastColor;
        ERROR:     errorCode <= errKind;
        default:   ;
      endcase
    end
  end

  // clearWord overrides the shift but still lets an accepting symbol land in the fresh word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word        <= '0;
      symbolCount <= 4'd0;
      wordValid   <= 1'b0;
    end else begin
      wordValid <= 1'b0;
      if (bus.clearWord) begin
        if (state == ACCEPT) begin
          word        <= {{(2*SYMBOLS-2){1'b0}}, lastColor};
          symbolCount <= 4'd1;
        end else begin
          word        <= '0;
          symbolCount <= 4'd0;
        end
      end else if (state == ACCEPT) begin
        word <= {word[2*SYMBOLS-3:0], lastColor};
        if (symbolCount == 4'(SYMBOLS - 1)) begin
          symbolCount <= 4'd0;
          wordValid   <= 1'b1;
        end else begin
          symbolCount <= symbolCount + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_color_symbol_reader.sv
// Scoreboard bench: a detector model answers start pulses from a reading queue, a monitor
// pops expected symbol/error events whenever the reader emits one.
module tb_color_symbol_reader;
  localparam int          SYMBOLS = 4;
  localparam int          CONFIRM = 3;
  localparam int          MAXT    = 8;
  localparam int          GAP     = 8;
  localparam logic [23:0] TMO     = 24'd100;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clrMain = 1'b0, clrDet = 1'b0;

  color_symbol_reader_if #(.SYMBOLS(SYMBOLS)) bus ();

  color_symbol_reader #(
    .SYMBOLS(SYMBOLS), .CONFIRM(CONFIRM), .MAX_TRIES(MAXT),
    .GAP_CYCLES(GAP), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  assign bus.clearWord = clrMain | clrDet;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nCmp = 0, nFail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] col;
    int         dly;   // 0 = detector never answers
    bit         clr;   // raise clearWord on the cycle the reader sits in ACCEPT
  } rd_t;

  typedef struct {
    bit         isErr;
    logic [1:0] sym;
    logic [7:0] word;
    logic [3:0] cnt;
    bit         wv;
    logic [1:0] code;
  } exp_t;

  rd_t  rdQ[$];
  exp_t expQ[$];
  int   prevStart = -1, prevDly = 0, startCyc = 0, errCyc = 0;

  // Detector model
  initial begin
    rd_t r;
    bus.detectionComplete = 1'b0;
    bus.color = 2'd0;
    forever begin
      @(posedge clk); #1;
      if (reset && bus.startDetection) begin
        startCyc = cyc;
        if (prevStart >= 0) check("start spacing", cyc - prevStart, prevDly + 1 + GAP);
        if (rdQ.size() == 0) begin
          nCmp++; nFail++;
          $display("FAIL unexpected start: got a start pulse, expected no further reading");
        end else begin
          r = rdQ.pop_front();
          if (r.dly > 0) begin
            repeat (r.dly - 1) @(posedge clk);
            #1;
            bus.color = r.col;
            bus.detectionComplete = 1'b1;
            @(posedge clk); #1;
            bus.detectionComplete = 1'b0;
            prevStart = startCyc;
            prevDly = r.dly;
            if (r.clr) begin
              clrDet = 1'b1;
              @(posedge clk); #1;
              clrDet = 1'b0;
            end
          end else begin
            prevStart = -1;
          end
        end
      end
    end
  end

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (bus.symbolValid || bus.error) begin
        if (expQ.size() == 0) begin
          nCmp++; nFail++;
          $display("FAIL unexpected event: got symbolValid=%0b error=%0b, expected none",
                   bus.symbolValid, bus.error);
        end else begin
          e = expQ.pop_front();
          check("event is error", bus.error, e.isErr);
          if (e.isErr) begin
            errCyc = cyc;
            check("errorCode", bus.errorCode, e.code);
          end else begin
            check("symbol", bus.symbol, e.sym);
          end
          check("word", bus.word, e.word);
          check("symbolCount", bus.symbolCount, e.cnt);
          check("wordValid", bus.wordValid, e.wv);
        end
      end else if (bus.wordValid) begin
        nCmp++; nFail++;
        $display("FAIL stray wordValid: got 1 without symbolValid, expected 0");
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic addRd(input logic [1:0] c, input int d, input bit clr);
    rd_t r;
    r.col = c; r.dly = d; r.clr = clr;
    rdQ.push_back(r);
  endtask

  task automatic pulseReq();
    @(posedge clk); #1 bus.readRequest = 1'b1;
    @(posedge clk); #1 bus.readRequest = 1'b0;
  endtask

  task automatic doRead(input bit isErr, input logic [1:0] sym, input logic [7:0] w,
                        input logic [3:0] cnt, input bit wv, input logic [1:0] code,
                        input bit extraReq);
    exp_t e;
    int   n;
    bit   done;
    e.isErr = isErr; e.sym = sym; e.word = w; e.cnt = cnt; e.wv = wv; e.code = code;
    expQ.push_back(e);
    prevStart = -1;
    pulseReq();
    n = 0; done = 0;
    while (!done) begin
      @(posedge clk); #1;
      n++;
      bus.readRequest = (extraReq && n == 3);
      if (n > 1 && !bus.busy) done = 1;
      else if (n > 3000) begin
        nCmp++; nFail++;
        $display("FAIL read timeout: busy still high after %0d cycles, expected low", n);
        done = 1;
      end
    end
    bus.readRequest = 1'b0;
    check("readings consumed", rdQ.size(), 0);
    if (isErr) check("errorCode held", bus.errorCode, code);
  endtask

  logic [7:0] w3 [4];
  logic [3:0] c3 [4];

  initial begin
    bus.readRequest = 1'b0;
    w3 = '{8'h00, 8'h01, 8'h06, 8'h1B};
    c3 = '{4'd1, 4'd2, 4'd3, 4'd0};
    repeat (3) @(posedge clk);
    #1;
    check("reset startDetection", bus.startDetection, 0);
    check("reset busy", bus.busy, 0);
    check("reset symbolValid", bus.symbolValid, 0);
    check("reset symbol", bus.symbol, 0);
    check("reset word", bus.word, 0);
    check("reset symbolCount", bus.symbolCount, 0);
    check("reset wordValid", bus.wordValid, 0);
    check("reset error", bus.error, 0);
    check("reset errorCode", bus.errorCode, 0);
    reset = 1'b1;

    // red x3 with varied detector latency
    addRd(2'd0, 3, 0); addRd(2'd0, 5, 0); addRd(2'd0, 2, 0);
    doRead(0, 2'b00, 8'h00, 4'd1, 0, 2'b00, 0);

    // G,G,B,B,B: color change restarts the match count; stray readRequest while busy
    addRd(2'd1, 2, 0); addRd(2'd1, 2, 0);
    addRd(2'd2, 2, 0); addRd(2'd2, 2, 0); addRd(2'd2, 2, 0);
    doRead(0, 2'b10, 8'h02, 4'd2, 0, 2'b00, 1);

    @(posedge clk); #1 clrMain = 1'b1;
    @(posedge clk); #1 clrMain = 1'b0;
    check("clear word", bus.word, 0);
    check("clear symbolCount", bus.symbolCount, 0);

    // R,G,B,Y fills the word
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < 3; k++) addRd(2'(s), 1, 0);
      doRead(0, 2'(s), w3[s], c3[s], (s == 3), 2'b00, 0);
    end
    check("full word held", bus.word, 8'h1B);

    // alternating R,G exhausts the tries
    for (int k = 0; k < 8; k++) addRd(2'(k % 2), 1, 0);
    doRead(1, 2'b00, 8'h1B, 4'd0, 0, 2'b10, 0);

    // silent detector: start seen at cycle s, timer 0..99, ERROR state, error pulse one later
    addRd(2'd0, 0, 0);
    doRead(1, 2'b00, 8'h1B, 4'd0, 0, 2'b01, 0);
    check("timeout latency", errCyc - startCyc, 101);

    // result on the last timer cycle wins over the timeout
    addRd(2'd3, 100, 0); addRd(2'd3, 1, 0); addRd(2'd3, 1, 0);
    doRead(0, 2'b11, 8'h6F, 4'd1, 0, 2'b00, 0);
    check("errorCode cleared by request", bus.errorCode, 0);

    // reset while in GAP aborts silently
    addRd(2'd0, 2, 0);
    prevStart = -1;
    pulseReq();
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("gap reset busy", bus.busy, 0);
    check("gap reset word", bus.word, 0);
    check("gap reset symbolCount", bus.symbolCount, 0);
    check("gap reset symbol", bus.symbol, 0);
    check("gap reset startDetection", bus.startDetection, 0);
    @(posedge clk); #1 reset = 1'b1;
    check("gap reset readings", rdQ.size(), 0);

    // clearWord landing on ACCEPT keeps only the new symbol
    for (int k = 0; k < 3; k++) addRd(2'd1, 1, 0);
    doRead(0, 2'b01, 8'h01, 4'd1, 0, 2'b00, 0);
    addRd(2'd2, 1, 0); addRd(2'd2, 1, 0); addRd(2'd2, 1, 1);
    doRead(0, 2'b10, 8'h02, 4'd1, 0, 2'b00, 0);

    repeat (5) @(posedge clk);
    check("expected events drained", expQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
